// File: rtl/fg_prog_pkg.sv
// fg_prog_pkg
// Shared types for the floating-gate programming sequencer.
//   mode_e  : command mode encoding as presented on cmd_mode
//   state_e : sequencer FSM states
//   REP_W   : width of the repeat count field/counter
//   is_pulse_mode() : true for modes that drive a programming pulse
package fg_prog_pkg;

  typedef enum logic [1:0] {
    MODE_READ   = 2'b00,
    MODE_INJECT = 2'b01,
    MODE_TUNNEL = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_MEAS,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int REP_W = 8;

  function automatic logic is_pulse_mode(input mode_e m);
    return (m == MODE_INJECT) || (m == MODE_TUNNEL);
  endfunction

endpackage

// File: rtl/fg_prog_timer.sv
// fg_prog_timer
// Loadable down-counter used for both settle and pulse intervals.
// Loading N-1 makes the zero flag rise in the N-th cycle after the load,
// so an N-cycle state ends when zero is seen. The counter parks at 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over en)
//   en         : decrement while non-zero
//   load_val   : value to load
//   zero       : count is zero
module fg_prog_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// fg_prog_sequencer
// Timed, abortable programming sequencer for a multi-island floating-gate
// crossbar. Takes one command over a valid/ready handshake and drives the
// decoder addresses, island select, drain select, program switch and tunnel
// supply enable through SETUP -> (PULSE/HOLD)* or MEAS/HOLD -> DONE.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE out of reset)
//   cmd_island/row/col  : target cell
//   cmd_mode            : 00 READ, 01 INJECT, 10 TUNNEL, 11 reserved
//   cmd_pulse           : pulse length in cycles
//   cmd_repeat          : number of pulses (0 behaves as 1)
//   abort               : end the current command early
//   isl_sel             : one-hot island select
//   vdec_addr/hdec_addr : vertical / horizontal decoder addresses
//   dec_en              : decoders enabled
//   drain_en/prog_sw_en/vtun_en : drain select, program switch, tunnel supply
//   meas_strobe         : one-cycle read sample strobe
//   busy                : not IDLE
//   done/err            : one-cycle completion / rejection pulses
//   aborted             : qualifies done when the command was aborted
module fg_prog_sequencer
  import fg_prog_pkg::*;
#(
  parameter  int NUM_ISLANDS = 2,
  parameter  int ROWS        = 16,
  parameter  int COLS        = 32,
  parameter  int ROW_BITS    = 6,
  parameter  int COL_BITS    = 6,
  parameter  int PULSE_W     = 16,
  parameter  int SETTLE_CYC  = 4,
  localparam int ISL_W       = (NUM_ISLANDS > 1) ? $clog2(NUM_ISLANDS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ISL_W-1:0]       cmd_island,
  input  logic [ROW_BITS-1:0]    cmd_row,
  input  logic [COL_BITS-1:0]    cmd_col,
  input  logic [1:0]             cmd_mode,
  input  logic [PULSE_W-1:0]     cmd_pulse,
  input  logic [REP_W-1:0]       cmd_repeat,
  input  logic                   abort,
  output logic [NUM_ISLANDS-1:0] isl_sel,
  output logic [ROW_BITS-1:0]    vdec_addr,
  output logic [COL_BITS-1:0]    hdec_addr,
  output logic                   dec_en,
  output logic                   drain_en,
  output logic                   prog_sw_en,
  output logic                   vtun_en,
  output logic                   meas_strobe,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   aborted
);

  localparam logic [PULSE_W-1:0] SETTLE_LOAD = PULSE_W'(SETTLE_CYC - 1);

  state_e               state_reg, state_next;
  mode_e                mode_reg, mode_next;
  mode_e                cmd_mode_e;
  logic [PULSE_W-1:0]   pulse_reg;
  logic [ISL_W-1:0]     isl_reg, isl_next;
  logic [ROW_BITS-1:0]  row_reg, row_next;
  logic [COL_BITS-1:0]  col_reg, col_next;
  logic [REP_W-1:0]     rep_reg, rep_next;
  logic                 abort_flag_reg, abort_flag_next;
  logic [NUM_ISLANDS-1:0] isl_onehot_next;

  logic                 accept;
  logic                 cmd_bad;
  logic                 addr_active;
  logic                 timer_load;
  logic [PULSE_W-1:0]   timer_val;
  logic                 timer_zero;

  assign cmd_ready  = (state_reg == ST_IDLE) && rst_n;
  assign busy       = (state_reg != ST_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign cmd_mode_e = mode_e'(cmd_mode);

  // Rejected commands never reach SETUP, so no address or enable is driven.
  assign cmd_bad = (32'(cmd_island) >= NUM_ISLANDS) ||
                   (32'(cmd_row) >= ROWS) ||
                   (32'(cmd_col) >= COLS) ||
                   (cmd_mode_e == MODE_RSVD) ||
                   ((cmd_pulse == '0) && is_pulse_mode(cmd_mode_e));

  // Output registers are loaded from the values the state being entered
  // will use, so a freshly accepted command shows its address in cycle 1.
  assign mode_next = accept ? cmd_mode_e : mode_reg;
  assign isl_next  = accept ? cmd_island : isl_reg;
  assign row_next  = accept ? cmd_row    : row_reg;
  assign col_next  = accept ? cmd_col    : col_reg;

  for (genvar gi = 0; gi < NUM_ISLANDS; gi++) begin : g_isl_dec
    assign isl_onehot_next[gi] = (32'(isl_next) == gi);
  end

  fg_prog_timer #(
    .W (PULSE_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .en       (1'b1),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // Next-state and interval-timer control. The timer is reloaded only on
  // transitions into a timed state; otherwise it free-runs down to zero.
  always_comb begin
    state_next      = state_reg;
    rep_next        = rep_reg;
    abort_flag_next = abort_flag_reg;
    timer_load      = 1'b0;
    timer_val       = SETTLE_LOAD;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          abort_flag_next = 1'b0;
          if (cmd_bad) begin
            state_next = ST_ERR;
          end else begin
            state_next = ST_SETUP;
            timer_load = 1'b1;
            // rep counts pulses still owed after the first one.
            if ((cmd_mode_e == MODE_READ) || (cmd_repeat == '0)) begin
              rep_next = '0;
            end else begin
              rep_next = cmd_repeat - REP_W'(1);
            end
          end
        end
      end
      ST_SETUP: begin
        if (abort) begin
          abort_flag_next = 1'b1;
          state_next      = ST_HOLD;
          timer_load      = 1'b1;
        end else if (timer_zero) begin
          if (mode_reg == MODE_READ) begin
            state_next = ST_MEAS;
          end else begin
            state_next = ST_PULSE;
            timer_load = 1'b1;
            timer_val  = pulse_reg - PULSE_W'(1);
          end
        end
      end
      ST_PULSE: begin
        if (abort) begin
          abort_flag_next = 1'b1;
        end
        if (abort || timer_zero) begin
          state_next = ST_HOLD;
          timer_load = 1'b1;
        end
      end
      ST_MEAS: begin
        if (abort) begin
          abort_flag_next = 1'b1;
        end
        state_next = ST_HOLD;
        timer_load = 1'b1;
      end
      ST_HOLD: begin
        // An abort here lets the settle run out but cancels further pulses.
        if (abort) begin
          abort_flag_next = 1'b1;
        end
        if (timer_zero) begin
          if ((rep_reg != '0) && !abort && !abort_flag_reg) begin
            state_next = ST_PULSE;
            rep_next   = rep_reg - REP_W'(1);
            timer_load = 1'b1;
            timer_val  = pulse_reg - PULSE_W'(1);
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign addr_active = (state_next == ST_SETUP) || (state_next == ST_PULSE) ||
                       (state_next == ST_HOLD)  || (state_next == ST_MEAS);

  // FSM state, command fields and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      mode_reg       <= MODE_READ;
      pulse_reg      <= '0;
      isl_reg        <= '0;
      row_reg        <= '0;
      col_reg        <= '0;
      rep_reg        <= '0;
      abort_flag_reg <= 1'b0;
      isl_sel        <= '0;
      vdec_addr      <= '0;
      hdec_addr      <= '0;
      dec_en         <= 1'b0;
      drain_en       <= 1'b0;
      prog_sw_en     <= 1'b0;
      vtun_en        <= 1'b0;
      meas_strobe    <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      aborted        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rep_reg        <= rep_next;
      abort_flag_reg <= abort_flag_next;
      if (accept) begin
        mode_reg  <= cmd_mode_e;
        pulse_reg <= cmd_pulse;
        isl_reg   <= cmd_island;
        row_reg   <= cmd_row;
        col_reg   <= cmd_col;
      end
      isl_sel     <= addr_active ? isl_onehot_next : '0;
      vdec_addr   <= addr_active ? row_next : '0;
      hdec_addr   <= addr_active ? col_next : '0;
      dec_en      <= addr_active;
      // READ keeps the drain selected through settle and sample; INJECT
      // needs it only while the program switch is closed.
      drain_en    <= ((state_next == ST_SETUP) && (mode_next == MODE_READ)) ||
                     (state_next == ST_MEAS) ||
                     ((state_next == ST_PULSE) && (mode_next == MODE_INJECT));
      prog_sw_en  <= (state_next == ST_PULSE) && (mode_next == MODE_INJECT);
      vtun_en     <= (state_next == ST_PULSE) && (mode_next == MODE_TUNNEL);
      meas_strobe <= (state_next == ST_MEAS);
      done        <= (state_next == ST_DONE);
      err         <= (state_next == ST_ERR);
      aborted     <= (state_next == ST_DONE) && abort_flag_next;
    end
  end

endmodule
